fifo_burst_reader: RTL and testbench

- Read-side master for the synchronous FIFO.
- On a start command, fetches exactly burst_len words through the FIFO read port (r_en with 1-cycle registered data_r / o_valid response).
- Presents the words downstream as a valid/ready stream, with last marking the final word.
- A 2-entry output buffer absorbs the FIFO read latency and sustains 1 word/cycle when the FIFO is non-empty and the sink is always ready.

---
 rtl/fifo_burst_reader.sv | 142 ++++++++++++++
 tb/tb_fifo_burst_reader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Read-side burst master for the synchronous FIFO: fetches burst_len words through the
// FIFO read port and replays them as a valid/ready stream through a 2-entry skid buffer.
module fifo_burst_reader #(
    parameter int D_WIDTH = 32,
    parameter int LEN_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [LEN_W-1:0]   burst_len,
    input  logic               fifo_empty,
    output logic               fifo_r_en,
    input  logic [D_WIDTH-1:0] fifo_data_r,
    input  logic               fifo_o_valid,
    output logic               m_valid,
    output logic [D_WIDTH-1:0] m_data,
    output logic               m_last,
    input  logic               m_ready,
    output logic               busy,
    output logic               done,
    output logic               rd_err
);

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t             state;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   req_cnt;
    logic [LEN_W-1:0]   del_cnt;
    logic [1:0]         occ;
    logic               infl;
    logic               rst_seen;
    logic [D_WIDTH-1:0] buf_p0;
    logic [D_WIDTH-1:0] buf_p1;

    logic               pop;
    logic               push;
    logic               stray;
    logic               last_word;
    logic [2:0]         committed;
    logic               room;

    assign pop       = m_valid && m_ready;
    assign push      = infl && fifo_o_valid;
    // A response in the first cycle after reset release may belong to a read issued
    // before the reset, so it is not counted as an error.
    assign stray     = fifo_o_valid && !infl && rst_seen;
    assign last_word = (del_cnt == len - ONE);

    // Buffered words plus the read in flight must leave space for one more word,
    // counting the slot freed by a pop happening this cycle.
    assign committed = {1'b0, occ} + {2'b00, infl};
    assign room      = committed < (3'd2 + {2'b00, pop});

    assign fifo_r_en = (state == BURST) && !fifo_empty && (req_cnt < len) && room;
    assign m_valid   = (occ != 2'd0);
    assign m_data    = buf_p0;
    assign m_last    = m_valid && last_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            len      <= '0;
            req_cnt  <= '0;
            del_cnt  <= '0;
            occ      <= 2'd0;
            infl     <= 1'b0;
            rst_seen <= 1'b0;
            buf_p0   <= '0;
            buf_p1   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            rst_seen <= 1'b1;
            infl     <= fifo_r_en;
            done     <= 1'b0;

            if (fifo_r_en)
                req_cnt <= req_cnt + ONE;
            if (pop)
                del_cnt <= del_cnt + ONE;
            if (stray)
                rd_err <= 1'b1;

            // Buffer stage: tail write on read return, head shift on pop
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0)
                        buf_p0 <= fifo_data_r;
                    else
                        buf_p1 <= fifo_data_r;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf_p0 <= buf_p1;
                    occ    <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf_p0 <= fifo_data_r;
                    end else begin
                        buf_p0 <= buf_p1;
                        buf_p1 <= fifo_data_r;
                    end
                end
                default: ;
            endcase

            case (state)
                IDLE: begin
                    if (start) begin
                        if (burst_len != '0) begin
                            len     <= burst_len;
                            req_cnt <= '0;
                            del_cnt <= '0;
                            rd_err  <= stray;
                            busy    <= 1'b1;
                            state   <= BURST;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (pop && last_word) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: table of burst scenarios against a FIFO model and a
// scoreboard of expected stream words, plus hand sequences for rd_err and mid-burst reset.
module tb_fifo_burst_reader;

    localparam int DW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [LW-1:0] burst_len;
    logic          fifo_empty;
    logic          fifo_r_en;
    logic [DW-1:0] fifo_data_r = '0;
    logic          fifo_o_valid;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;
    logic          busy;
    logic          done;
    logic          rd_err;

    always #5 clk = ~clk;

    fifo_burst_reader #(.D_WIDTH(DW), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .burst_len(burst_len),
        .fifo_empty(fifo_empty), .fifo_r_en(fifo_r_en), .fifo_data_r(fifo_data_r),
        .fifo_o_valid(fifo_o_valid), .m_valid(m_valid), .m_data(m_data),
        .m_last(m_last), .m_ready(m_ready), .busy(busy), .done(done), .rd_err(rd_err)
    );

    // FIFO model: one-cycle registered read response
    logic [DW-1:0] fmem [256];
    logic [7:0]    wptr;
    logic [7:0]    rptr = 8'd0;
    logic          fm_valid = 1'b0;
    logic          force_ov;

    assign fifo_empty   = (wptr == rptr);
    assign fifo_o_valid = fm_valid | force_ov;

    always @(posedge clk) begin
        if (fifo_r_en && !fifo_empty) begin
            fifo_data_r <= fmem[rptr];
            rptr        <= rptr + 8'd1;
            fm_valid    <= 1'b1;
        end else begin
            fm_valid <= 1'b0;
        end
    end

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        int            len;
        int            preload;
        int            late_words;
        int            late_at;
        logic [DW-1:0] base;
        logic [15:0]   ready_pat;
        int            restart_at;
        int            exp_xfers;
        int            exp_dones;
        int            exp_span;
        int            exp_ren_lat;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    int   cyc = 0;
    int   rd_issued, pops, done_cnt, done_cyc, first_ren, first_valid, first_pop, last_pop;
    logic busy_at_done;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic prev_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_write(input logic [DW-1:0] w);
        fmem[wptr] = w;
        wptr = wptr + 8'd1;
    endtask

    task automatic clear_counters();
        rd_issued = 0; pops = 0; done_cnt = 0; done_cyc = -1;
        first_ren = -1; first_valid = -1; first_pop = -1; last_pop = -1;
        busy_at_done = 1'bx;
    endtask

    task automatic monitor();
        exp_t e;
        int   outst;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", m_valid, 1);
                    check("stall_data", m_data, prev_data);
                    check("stall_last", m_last, prev_last);
                end
                if (m_last)
                    check("last_without_valid", m_valid, 1);
                if (fifo_r_en) begin
                    outst = rd_issued - pops - ((m_valid && m_ready) ? 1 : 0);
                    check("ren_while_empty", fifo_empty, 0);
                    check("ren_over_buffer", (outst < 2), 1);
                    if (first_ren < 0) first_ren = cyc;
                    rd_issued++;
                end
                if (m_valid && first_valid < 0)
                    first_valid = cyc;
                if (m_valid && m_ready) begin
                    pops++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL extra_word: got %0h, expected no transfer", m_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("word_data", m_data, e.data);
                        check("word_last", m_last, e.last);
                    end
                    if (first_pop < 0) first_pop = cyc;
                    if (m_last) last_pop = cyc;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc     = cyc;
                    busy_at_done = busy;
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_r_en"},   fifo_r_en, 0);
        check({tag, "_valid"},  m_valid, 0);
        check({tag, "_data"},   m_data, 0);
        check({tag, "_last"},   m_last, 0);
        check({tag, "_busy"},   busy, 0);
        check({tag, "_done"},   done, 0);
        check({tag, "_rd_err"}, rd_err, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int start_cyc;
        int settle;
        bit finished;
        clear_counters();
        for (int i = 0; i < v.len; i++)
            exp_q.push_back('{data: v.base + DW'(i), last: (i == v.len - 1)});
        for (int i = 0; i < v.preload; i++)
            fifo_write(v.base + DW'(i));
        start     = 1'b1;
        burst_len = LW'(v.len);
        m_ready   = v.ready_pat[0];
        start_cyc = cyc + 1;
        settle    = 0;
        finished  = 0;
        for (int k = 1; k <= 150 && !finished; k++) begin
            tick();
            start     = (k == v.restart_at);
            burst_len = (k == v.restart_at) ? LW'(3) : LW'(v.len);
            m_ready   = v.ready_pat[k % 16];
            if (k == v.late_at)
                for (int i = 0; i < v.late_words; i++)
                    fifo_write(v.base + DW'(v.preload + i));
            if (done_cnt >= v.exp_dones && exp_q.size() == 0) begin
                settle++;
                if (settle == 4) finished = 1;
            end
        end
        check("burst_finished", finished, 1);
        check("xfer_count", pops, v.exp_xfers);
        check("done_count", done_cnt, v.exp_dones);
        check("scoreboard_drained", exp_q.size(), 0);
        check("idle_after_burst", busy, 0);
        check("no_rd_err", rd_err, 0);
        if (v.len == 0) begin
            check("zero_done_latency", done_cyc - start_cyc, 1);
            check("zero_busy", busy_at_done, 0);
            check("zero_no_reads", rd_issued, 0);
        end else begin
            check("done_after_last", done_cyc - last_pop, 1);
            check("busy_at_done", busy_at_done, 1);
            check("read_latency", first_valid - first_ren, 2);
            check("read_count", rd_issued, v.len);
            if (v.exp_span >= 0)
                check("no_bubbles", last_pop - first_pop, v.exp_span);
            if (v.exp_ren_lat >= 0)
                check("start_to_ren", first_ren - start_cyc, v.exp_ren_lat);
        end
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vec_t v;
        bit   ok;

        vecs[0] = '{len: 4, preload: 4, late_words: 0, late_at: -1, base: 32'hA0, ready_pat: 16'hFFFF,
                    restart_at: -1, exp_xfers: 4, exp_dones: 1, exp_span: 3, exp_ren_lat: 1};
        vecs[1] = '{len: 3, preload: 3, late_words: 0, late_at: -1, base: 32'hB0, ready_pat: 16'hFFF9,
                    restart_at: -1, exp_xfers: 3, exp_dones: 1, exp_span: -1, exp_ren_lat: 1};
        vecs[2] = '{len: 2, preload: 0, late_words: 2, late_at: 5, base: 32'hC0, ready_pat: 16'hFFFF,
                    restart_at: -1, exp_xfers: 2, exp_dones: 1, exp_span: 1, exp_ren_lat: -1};
        vecs[3] = '{len: 0, preload: 0, late_words: 0, late_at: -1, base: 32'h0, ready_pat: 16'hFFFF,
                    restart_at: -1, exp_xfers: 0, exp_dones: 1, exp_span: -1, exp_ren_lat: -1};
        vecs[4] = '{len: 8, preload: 8, late_words: 0, late_at: -1, base: 32'hD0, ready_pat: 16'hFFFF,
                    restart_at: 3, exp_xfers: 8, exp_dones: 1, exp_span: 7, exp_ren_lat: 1};
        vecs[5] = '{len: 5, preload: 5, late_words: 0, late_at: -1, base: 32'h50, ready_pat: 16'h5555,
                    restart_at: -1, exp_xfers: 5, exp_dones: 1, exp_span: -1, exp_ren_lat: 1};

        rst_n = 1'b1; start = 1'b0; burst_len = '0; m_ready = 1'b0; force_ov = 1'b0; wptr = 8'd0;
        clear_counters();
        fork
            monitor();
        join_none
        #1 rst_n = 1'b0;
        #1 check_idle_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++)
            run_vec(vecs[i]);

        // Spurious read response in IDLE sets a sticky error; the next burst clears it
        force_ov = 1'b1;
        tick();
        force_ov = 1'b0;
        check("rd_err_set", rd_err, 1);
        repeat (3) tick();
        check("rd_err_sticky", rd_err, 1);
        v = '{len: 1, preload: 1, late_words: 0, late_at: -1, base: 32'hF1, ready_pat: 16'hFFFF,
              restart_at: -1, exp_xfers: 1, exp_dones: 1, exp_span: 0, exp_ren_lat: 1};
        run_vec(v);

        // Reset after two words of a six-word burst
        clear_counters();
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back('{data: 32'hE0 + DW'(i), last: (i == 5)});
            fifo_write(32'hE0 + DW'(i));
        end
        start = 1'b1; burst_len = LW'(6); m_ready = 1'b1;
        tick();
        start = 1'b0;
        ok = 0;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (pops >= 2) ok = 1;
            else tick();
        end
        check("pre_reset_progress", ok, 1);
        check("pre_reset_pops", pops, 2);
        rst_n = 1'b0;
        #1 check_idle_outputs("midburst_reset");
        exp_q.delete();
        tick();
        tick();
        wptr     = rptr;
        rst_n    = 1'b1;
        force_ov = 1'b1;
        tick();
        force_ov = 1'b0;
        check("post_reset_rd_err", rd_err, 0);
        check("post_reset_busy", busy, 0);
        check("post_reset_valid", m_valid, 0);
        v = '{len: 2, preload: 2, late_words: 0, late_at: -1, base: 32'h70, ready_pat: 16'hFFFF,
              restart_at: -1, exp_xfers: 2, exp_dones: 1, exp_span: 1, exp_ren_lat: 1};
        run_vec(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
